fpga_mode_sequencer: RTL and testbench

Synchronous replacement for the SPI configuration receiver and major-mode select at the FPGA top level. It oversamples the ARM's SPI lines in the `ck_1356meg` domain and decodes 16-bit command frames into `conf_word`, `divisor` and `conf_enio`. Major-mode changes are sequenced so that the output muxes never switch while a mode is driving the antenna: coil drivers are quiesced, the mode is switched, and the new mode is given time to settle before it is reported active. The block sits between the SPI pins and the `mux8` bank; its `major_mode` output drives the mux selects.

---
 rtl/fpga_mode_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fpga_mode_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_mode_sequencer.sv
// SPI command receiver and major-mode sequencer for the FPGA top level.
// Coil drivers are quiesced around every major-mode switch of the mux bank.
module fpga_mode_sequencer #(
    parameter int unsigned GUARD_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 32
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    output logic [7:0] conf_word,
    output logic [2:0] major_mode,
    output logic [7:0] divisor,
    output logic [7:0] conf_enio,
    output logic       quiesce,
    output logic       mode_busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {RUN, QUIESCE, SWITCH, SETTLE} state_t;

    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic        spck_s1_q, spck_s2_q, spck_h_q;
    logic        ncs_s1_q, ncs_s2_q, ncs_h_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        cmd_vld_q, cmd_ok_q;
    logic [3:0]  cmd_code_q;
    logic [7:0]  cmd_data_q;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  conf_q, conf_d;
    logic [2:0]  major_q, major_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [7:0]  enio_q, enio_d;
    logic        frame_err_q, frame_err_d;

    logic        spck_rise, ncs_fall, ncs_rise;
    logic        wr_target, wr_div, wr_enio;

    assign spck_rise = spck_s2_q && !spck_h_q;
    assign ncs_fall  = !ncs_s2_q && ncs_h_q;
    assign ncs_rise  = ncs_s2_q && !ncs_h_q;

    assign wr_target = cmd_vld_q && cmd_ok_q && (cmd_code_q == 4'b0001);
    assign wr_div    = cmd_vld_q && cmd_ok_q && (cmd_code_q == 4'b0010);
    assign wr_enio   = cmd_vld_q && cmd_ok_q && (cmd_code_q == 4'b0100);

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = ncs_fall ? 5'd0 : bitcnt_q;
        if (spck_rise && !ncs_s2_q) begin
            shift_d = {shift_q[14:0], mosi_s2_q};
            if (bitcnt_d != 5'd17) bitcnt_d = bitcnt_d + 5'd1;
        end
    end

    // ncs synchronisers reset high so a reset release never looks like a frame edge
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            spck_s1_q  <= 1'b0;
            spck_s2_q  <= 1'b0;
            spck_h_q   <= 1'b0;
            ncs_s1_q   <= 1'b1;
            ncs_s2_q   <= 1'b1;
            ncs_h_q    <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            shift_q    <= 16'h0000;
            bitcnt_q   <= 5'd0;
            cmd_vld_q  <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_code_q <= 4'h0;
            cmd_data_q <= 8'h00;
        end else begin
            spck_s1_q  <= spck;
            spck_s2_q  <= spck_s1_q;
            spck_h_q   <= spck_s2_q;
            ncs_s1_q   <= ncs;
            ncs_s2_q   <= ncs_s1_q;
            ncs_h_q    <= ncs_s2_q;
            mosi_s1_q  <= mosi;
            mosi_s2_q  <= mosi_s1_q;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            cmd_vld_q  <= ncs_rise;
            cmd_ok_q   <= (bitcnt_q == 5'd16);
            cmd_code_q <= shift_q[15:12];
            cmd_data_q <= shift_q[7:0];
        end
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 8'h00;
            target_q    <= 8'hE0;
            conf_q      <= 8'hE0;
            major_q     <= 3'b111;
            divisor_q   <= 8'h00;
            enio_q      <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            conf_q      <= conf_d;
            major_q     <= major_d;
            divisor_q   <= divisor_d;
            enio_q      <= enio_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        conf_d      = conf_q;
        major_d     = major_q;
        target_d    = wr_target ? cmd_data_q : target_q;
        divisor_d   = wr_div ? cmd_data_q : divisor_q;
        enio_d      = wr_enio ? cmd_data_q : enio_q;
        frame_err_d = cmd_vld_q && !cmd_ok_q;
        case (state_q)
            RUN: begin
                if (target_q[7:5] != major_q) begin
                    state_d = QUIESCE;
                    cnt_d   = GUARD_LOAD;
                end else if (wr_target && (cmd_data_q[7:5] == major_q)) begin
                    conf_d[4:0] = cmd_data_q[4:0];
                end else begin
                    conf_d[4:0] = target_q[4:0];
                end
            end
            // The switch samples the newest target, including one landing this cycle
            QUIESCE: begin
                if (cnt_q == 8'd0) begin
                    state_d = SWITCH;
                    conf_d  = target_d;
                    major_d = target_d[7:5];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SWITCH: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    if (target_q[7:5] != major_q) begin
                        state_d = QUIESCE;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        state_d     = RUN;
                        conf_d[4:0] = target_q[4:0];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        quiesce    = (state_q == QUIESCE) || (state_q == SWITCH);
        mode_busy  = (state_q != RUN);
        major_mode = (state_q == QUIESCE) ? 3'b111 : major_q;
    end

    assign conf_word = conf_q;
    assign divisor   = divisor_q;
    assign conf_enio = enio_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fpga_mode_sequencer.sv
// Directed bench: instance A uses the default guard/settle, instance B a long
// guard/settle so a second frame can land inside QUIESCE or SETTLE.
module tb_fpga_mode_sequencer;

    localparam int HALF = 3;

    logic clk = 1'b0;
    logic rst, spck, ncs, mosi, sel_b, mon_clr;
    logic ncs_a, ncs_b;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] a_conf, a_div, a_enio, b_conf, b_div, b_enio;
    logic [2:0] a_major, b_major;
    logic       a_q, a_busy, a_ferr, b_q, b_busy, b_ferr;

    logic       q_arr [0:63];
    logic       b_arr [0:63];
    logic       e_arr [0:63];
    logic [2:0] m_arr [0:63];
    logic [7:0] c_arr [0:63];

    int         qr_b;
    logic       qb_prev;
    logic [7:0] seen_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ncs_a = ncs | sel_b;
    assign ncs_b = ncs | ~sel_b;

    fpga_mode_sequencer dut_a (
        .ck_1356meg(clk), .rst(rst), .spck(spck), .ncs(ncs_a), .mosi(mosi),
        .conf_word(a_conf), .major_mode(a_major), .divisor(a_div), .conf_enio(a_enio),
        .quiesce(a_q), .mode_busy(a_busy), .frame_err(a_ferr)
    );

    fpga_mode_sequencer #(.GUARD_CYCLES(200), .SETTLE_CYCLES(200)) dut_b (
        .ck_1356meg(clk), .rst(rst), .spck(spck), .ncs(ncs_b), .mosi(mosi),
        .conf_word(b_conf), .major_mode(b_major), .divisor(b_div), .conf_enio(b_enio),
        .quiesce(b_q), .mode_busy(b_busy), .frame_err(b_ferr)
    );

    always @(negedge clk) begin
        if (mon_clr) begin
            qr_b    <= 0;
            qb_prev <= 1'b0;
            seen_b  <= 8'h00;
        end else begin
            if (b_q && !qb_prev) qr_b <= qr_b + 1;
            qb_prev <= b_q;
            seen_b  <= seen_b | (8'd1 << b_major);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] data, input int nbits, input bit close);
        repeat (HALF) @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            repeat (HALF) @(negedge clk);
            spck = 1'b1;
            repeat (HALF) @(negedge clk);
            spck = 1'b0;
        end
        if (close) begin
            repeat (HALF) @(negedge clk);
            ncs = 1'b1;
        end
    endtask

    task automatic pulse_clr();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_bq(input logic level, input int budget, input string tag);
        int t;
        t = 0;
        while (b_q !== level && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, 32'(t < budget), 32'd1);
    endtask

    task automatic wait_b_idle(input int budget, input string tag);
        int t;
        t = 0;
        repeat (8) @(posedge clk);
        #1;
        while (b_busy !== 1'b0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, 32'(t < budget), 32'd1);
    endtask

    task automatic capture(input int n0, input int last);
        for (int k = 0; k <= last; k++) begin
            wait_cyc(n0 + k);
            q_arr[k] = a_q;
            b_arr[k] = a_busy;
            e_arr[k] = a_ferr;
            m_arr[k] = a_major;
            c_arr[k] = a_conf;
        end
    endtask

    initial begin
        int n0, qc, bc, ec;
        rst = 1'b1; spck = 1'b0; ncs = 1'b1; mosi = 1'b0; sel_b = 1'b0; mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_conf", 32'(a_conf), 32'hE0);
        chk("rst_major", 32'(a_major), 32'd7);
        chk("rst_div", 32'(a_div), 32'h00);
        chk("rst_enio", 32'(a_enio), 32'h00);
        chk("rst_quiesce", 32'(a_q), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ferr", 32'(a_ferr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(32'h2095, 16, 1'b1);
        n0 = cyc + 1;
        wait_cyc(n0 + 2);
        chk("div_before_n3", 32'(a_div), 32'h00);
        wait_cyc(n0 + 3);
        chk("div_at_n3", 32'(a_div), 32'h95);
        chk("div_major", 32'(a_major), 32'd7);
        chk("div_quiesce", 32'(a_q), 32'd0);
        chk("div_busy", 32'(a_busy), 32'd0);

        send(32'h1061, 16, 1'b1);
        n0 = cyc + 1;
        capture(n0, 60);
        qc = 0; bc = 0;
        for (int k = 0; k <= 60; k++) begin
            if (q_arr[k]) qc++;
            if (b_arr[k]) bc++;
        end
        chk("xm_q_n3", 32'(q_arr[3]), 32'd0);
        chk("xm_q_n4", 32'(q_arr[4]), 32'd1);
        chk("xm_q_n20", 32'(q_arr[20]), 32'd1);
        chk("xm_q_n21", 32'(q_arr[21]), 32'd0);
        chk("xm_q_len", 32'(qc), 32'd17);
        chk("xm_major_n19", 32'(m_arr[19]), 32'd7);
        chk("xm_major_n20", 32'(m_arr[20]), 32'd3);
        chk("xm_conf_n20", 32'(c_arr[20]), 32'h61);
        chk("xm_busy_n52", 32'(b_arr[52]), 32'd1);
        chk("xm_busy_n53", 32'(b_arr[53]), 32'd0);
        chk("xm_busy_len", 32'(bc), 32'd49);
        chk("xm_conf_end", 32'(a_conf), 32'h61);

        send(32'h1063, 16, 1'b1);
        n0 = cyc + 1;
        capture(n0, 10);
        qc = 0; bc = 0;
        for (int k = 0; k <= 10; k++) begin
            if (q_arr[k]) qc++;
            if (b_arr[k]) bc++;
        end
        chk("minor_conf_n2", 32'(c_arr[2]), 32'h61);
        chk("minor_conf_n3", 32'(c_arr[3]), 32'h63);
        chk("minor_no_quiesce", 32'(qc), 32'd0);
        chk("minor_no_busy", 32'(bc), 32'd0);
        chk("minor_major", 32'(a_major), 32'd3);

        send(32'h2011, 15, 1'b1);
        n0 = cyc + 1;
        capture(n0, 8);
        ec = 0;
        for (int k = 0; k <= 8; k++) if (e_arr[k]) ec++;
        chk("f15_err_n2", 32'(e_arr[2]), 32'd0);
        chk("f15_err_n3", 32'(e_arr[3]), 32'd1);
        chk("f15_err_len", 32'(ec), 32'd1);
        chk("f15_div", 32'(a_div), 32'h95);
        chk("f15_conf", 32'(a_conf), 32'h63);

        send(32'h12033, 17, 1'b1);
        n0 = cyc + 1;
        capture(n0, 8);
        ec = 0;
        for (int k = 0; k <= 8; k++) if (e_arr[k]) ec++;
        chk("f17_err_n3", 32'(e_arr[3]), 32'd1);
        chk("f17_err_len", 32'(ec), 32'd1);
        chk("f17_div", 32'(a_div), 32'h95);

        send(32'h4012, 16, 1'b1);
        n0 = cyc + 1;
        capture(n0, 8);
        ec = 0;
        for (int k = 0; k <= 8; k++) if (e_arr[k]) ec++;
        chk("enio_n3", 32'(a_enio), 32'h12);
        chk("enio_no_err", 32'(ec), 32'd0);

        sel_b = 1'b1;
        pulse_clr();
        send(32'h1040, 16, 1'b1);
        send(32'h1080, 16, 1'b1);
        wait_b_idle(3000, "qr_timeout");
        chk("qr_quiesce_count", 32'(qr_b), 32'd1);
        chk("qr_mode2_seen", 32'(seen_b[2]), 32'd0);
        chk("qr_major", 32'(b_major), 32'd4);
        chk("qr_conf", 32'(b_conf), 32'h80);

        pulse_clr();
        send(32'h1060, 16, 1'b1);
        wait_bq(1'b1, 100, "sr_q_rise_timeout");
        wait_bq(1'b0, 400, "sr_q_fall_timeout");
        send(32'h1080, 16, 1'b1);
        wait_b_idle(3000, "sr_timeout");
        chk("sr_quiesce_count", 32'(qr_b), 32'd2);
        chk("sr_mode3_seen", 32'(seen_b[3]), 32'd1);
        chk("sr_major", 32'(b_major), 32'd4);
        chk("sr_conf", 32'(b_conf), 32'h80);

        pulse_clr();
        send(32'h1040, 16, 1'b1);
        wait_bq(1'b1, 100, "wb_q_rise_timeout");
        wait_bq(1'b0, 400, "wb_q_fall_timeout");
        send(32'h1045, 16, 1'b1);
        wait_b_idle(3000, "wb_timeout");
        chk("wb_quiesce_count", 32'(qr_b), 32'd1);
        chk("wb_major", 32'(b_major), 32'd2);
        chk("wb_conf", 32'(b_conf), 32'h45);

        chk("a_isolated_conf", 32'(a_conf), 32'h63);
        chk("a_isolated_major", 32'(a_major), 32'd3);
        chk("a_isolated_div", 32'(a_div), 32'h95);

        sel_b = 1'b0;
        send(32'h2055, 8, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_conf", 32'(a_conf), 32'hE0);
        chk("arst_major", 32'(a_major), 32'd7);
        chk("arst_div", 32'(a_div), 32'h00);
        chk("arst_enio", 32'(a_enio), 32'h00);
        chk("arst_b_major", 32'(b_major), 32'd7);
        ncs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(32'h2077, 16, 1'b1);
        n0 = cyc + 1;
        capture(n0, 8);
        ec = 0;
        for (int k = 0; k <= 8; k++) if (e_arr[k]) ec++;
        chk("post_rst_div", 32'(a_div), 32'h77);
        chk("post_rst_no_err", 32'(ec), 32'd0);
        chk("post_rst_major", 32'(a_major), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
